// File: rtl/ntt_pkg.sv
// Shared constants, butterfly select codes and sequencer states for the
// Kyber NTT/INTT controller.
package ntt_pkg;
  localparam int N            = 256;
  localparam int LAYERS       = 7;
  localparam int BF_PER_LAYER = 64;

  localparam logic [1:0] SEL_NTT  = 2'd0;
  localparam logic [1:0] SEL_INTT = 2'd1;
  localparam logic [1:0] SEL_BYP  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly address / zeta index generator for one
// (mode, layer, idx) point of the transform schedule.
module ntt_addr_gen
  import ntt_pkg::*;
#(
  parameter int AW = 8,
  parameter int ZW = 7
) (
  input  logic          mode,
  input  logic [2:0]    layer,
  input  logic [5:0]    idx,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic [ZW-1:0] zeta_addr
);
  localparam logic [ZW-1:0] ZMAX = '1;

  logic [2:0]    lg;
  logic [AW-1:0] len;
  logic [AW-1:0] grp_a;
  logic [AW-1:0] off;
  logic [ZW-1:0] grp_z;

  always_comb begin
    // log2 of the butterfly span: shrinks per layer for NTT, grows for INTT
    lg        = mode ? (layer + 3'd1) : (3'd7 - layer);
    len       = AW'(1) << lg;
    grp_a     = AW'(idx) >> lg;
    off       = AW'(idx) & (len - AW'(1));
    addr_a    = (grp_a << ({1'b0, lg} + 4'd1)) | off;
    addr_b    = addr_a + len;
    grp_z     = ZW'(idx) >> lg;
    zeta_addr = mode ? ((ZMAX >> layer) - grp_z) : ((ZW'(1) << layer) + grp_z);
  end
endmodule

// File: rtl/ntt_ctrl.sv
// NTT/INTT sequencer: issues one butterfly per cycle over 7 layers and
// delays the operand addresses by the read+butterfly latency for write-back.
module ntt_ctrl
  import ntt_pkg::*;
#(
  parameter int AW     = 8,
  parameter int ZW     = 7,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  output logic [ZW-1:0] zeta_addr,
  output logic [1:0]    bf_sel,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr_a,
  output logic [AW-1:0] wr_addr_b
);
  localparam int PIPE = RD_LAT + BF_LAT;
  localparam int CW   = $clog2(PIPE + 1);

  localparam logic [2:0] IDLE  = S_IDLE;
  localparam logic [2:0] ISSUE = S_ISSUE;
  localparam logic [2:0] DRAIN = S_DRAIN;
  localparam logic [2:0] FLUSH = S_FLUSH;
  localparam logic [2:0] DONE  = S_DONE;

  logic [2:0]    state;
  logic          mode_q;
  logic [2:0]    layer;
  logic [5:0]    idx;
  logic [CW-1:0] cnt;

  logic [AW-1:0] gen_a, gen_b;
  logic [ZW-1:0] gen_z;

  ntt_addr_gen #(.AW(AW), .ZW(ZW)) u_addr_gen (
    .mode      (mode_q),
    .layer     (layer),
    .idx       (idx),
    .addr_a    (gen_a),
    .addr_b    (gen_b),
    .zeta_addr (gen_z)
  );

  assign rd_en     = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign rd_addr_a = rd_en ? gen_a : '0;
  assign rd_addr_b = rd_en ? gen_b : '0;
  assign zeta_addr = rd_en ? gen_z : '0;
  assign bf_sel    = busy ? (mode_q ? SEL_INTT : SEL_NTT) : SEL_BYP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mode_q <= 1'b0;
      layer  <= '0;
      idx    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state  <= ISSUE;
          mode_q <= mode;
          layer  <= '0;
          idx    <= '0;
        end
        ISSUE: begin
          idx <= idx + 6'd1;
          cnt <= '0;
          if (idx == 6'(BF_PER_LAYER - 1))
            state <= (layer == 3'(LAYERS - 1)) ? FLUSH : DRAIN;
        end
        // Hold off the next layer until every write of this one has landed
        DRAIN: if (cnt == CW'(PIPE - 1)) begin
          cnt   <= '0;
          layer <= layer + 3'd1;
          idx   <= '0;
          state <= ISSUE;
        end else cnt <= cnt + CW'(1);
        FLUSH: if (cnt == CW'(PIPE - 1)) begin
          cnt   <= '0;
          state <= DONE;
        end else cnt <= cnt + CW'(1);
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [PIPE:1]          vld_pipe;
  logic [PIPE:1][AW-1:0]  a_pipe, b_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      a_pipe   <= '0;
      b_pipe   <= '0;
    end else begin
      vld_pipe[1] <= rd_en;
      a_pipe[1]   <= rd_addr_a;
      b_pipe[1]   <= rd_addr_b;
      for (int k = 2; k <= PIPE; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        a_pipe[k]   <= a_pipe[k-1];
        b_pipe[k]   <= b_pipe[k-1];
      end
    end
  end

  assign wr_en     = vld_pipe[PIPE];
  assign wr_addr_a = a_pipe[PIPE];
  assign wr_addr_b = b_pipe[PIPE];
endmodule

// File: tb/tb_ntt_ctrl.sv
// Bench for ntt_ctrl: schedule model derived from cycle arithmetic, checked
// every cycle, plus literal address/timing points.
module tb_ntt_ctrl;
  localparam int PIPE     = 5;
  localparam int SPAN     = 64 + PIPE;
  localparam int DONE_CYC = 7 * SPAN + 1;

  logic       clk = 1'b0;
  logic       rst, start, mode;
  logic       busy, done, rd_en, wr_en;
  logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [6:0] zeta_addr;
  logic [1:0] bf_sel;

  always #5 clk = ~clk;

  ntt_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .zeta_addr(zeta_addr),
    .bf_sel(bf_sel), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Model state: act marks an accepted transform, rel is the current cycle
  // number counted from the start cycle (start sampled in cycle 0).
  bit act = 1'b0, md = 1'b0, armed = 1'b0;
  int rel = 0;

  always @(posedge clk) begin
    if (rst) act = 1'b0;
    else if (act) begin
      if (rel == DONE_CYC) act = 1'b0;
      else rel++;
    end else if (start) begin
      act = 1'b1;
      md  = mode;
      rel = 1;
    end
  end

  function automatic void bf_at(input bit m, input int k, output bit v,
                                output int a, output int b, output int z);
    int l, i, len, grp;
    v = 1'b0; a = 0; b = 0; z = 0;
    if (k < 1) return;
    l = (k - 1) / SPAN;
    i = (k - 1) % SPAN;
    if (l >= 7 || i >= 64) return;
    v   = 1'b1;
    len = m ? (2 << l) : (128 >> l);
    grp = i / len;
    a   = grp * 2 * len + i % len;
    b   = a + len;
    z   = m ? (128 >> l) - 1 - grp : (1 << l) + grp;
  endfunction

  always @(negedge clk) begin
    bit rv, wv;
    int ra, rb, rz, wa, wb, wz;
    if (armed) begin
      rv = 1'b0; wv = 1'b0;
      ra = 0; rb = 0; rz = 0; wa = 0; wb = 0; wz = 0;
      if (act) begin
        bf_at(md, rel, rv, ra, rb, rz);
        bf_at(md, rel - PIPE, wv, wa, wb, wz);
      end
      chk("busy",   busy,   act);
      chk("done",   done,   act && rel == DONE_CYC);
      chk("rd_en",  rd_en,  rv);
      chk("wr_en",  wr_en,  wv);
      chk("bf_sel", bf_sel, act ? {1'b0, md} : 2'd2);
      if (rv) begin
        chk("rd_addr_a", rd_addr_a, ra);
        chk("rd_addr_b", rd_addr_b, rb);
        chk("zeta_addr", zeta_addr, rz);
      end
      if (wv) begin
        chk("wr_addr_a", wr_addr_a, wa);
        chk("wr_addr_b", wr_addr_b, wb);
      end
      if (!act) begin
        chk("idle_rd_addr_a", rd_addr_a, 0);
        chk("idle_zeta",      zeta_addr, 0);
        chk("idle_wr_addr_b", wr_addr_b, 0);
      end
      // Hand-computed schedule points
      if (act && !md) begin
        case (rel)
          1:   begin chk("ntt_c1_a", rd_addr_a, 0);   chk("ntt_c1_b", rd_addr_b, 128); chk("ntt_c1_z", zeta_addr, 1);  end
          64:  begin chk("ntt_c64_a", rd_addr_a, 63); chk("ntt_c64_b", rd_addr_b, 191); end
          415: begin chk("ntt_l6_a", rd_addr_a, 0);   chk("ntt_l6_b", rd_addr_b, 2);   chk("ntt_l6_z", zeta_addr, 64); end
          478: begin chk("ntt_last_a", rd_addr_a, 125); chk("ntt_last_b", rd_addr_b, 127); chk("ntt_last_z", zeta_addr, 95); end
          483: chk("ntt_last_wr", wr_en, 1);
          484: chk("ntt_done484", done, 1);
          default: ;
        endcase
      end
      if (act && md) begin
        case (rel)
          1:   begin chk("intt_c1_a", rd_addr_a, 0);  chk("intt_c1_b", rd_addr_b, 2);   chk("intt_c1_z", zeta_addr, 127); end
          64:  begin chk("intt_c64_a", rd_addr_a, 125); chk("intt_c64_z", zeta_addr, 96); end
          415: begin chk("intt_l6_a", rd_addr_a, 0);  chk("intt_l6_b", rd_addr_b, 128); chk("intt_l6_z", zeta_addr, 1); end
          default: ;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    tick();
    armed = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // NTT with ignored re-start pulses and mode wiggles
    start = 1'b1; mode = 1'b0;
    tick();
    for (int c = 1; c <= DONE_CYC; c++) begin
      start = (c == 10 || c == 200);
      mode  = (c == 10 || c == 300);
      tick();
    end

    // start in the cycle after done is accepted: INTT
    start = 1'b1; mode = 1'b1;
    tick();
    for (int c = 1; c <= DONE_CYC; c++) begin
      start = (c == 50);
      mode  = (c % 7 == 0);
      tick();
    end
    start = 1'b0; mode = 1'b0;
    repeat (3) tick();

    // mid-operation reset
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (99) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_rd_en",  rd_en,  0);
    chk("rst_wr_en",  wr_en,  0);
    chk("rst_busy",   busy,   0);
    chk("rst_bf_sel", bf_sel, 2);
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
